qar_spi_seq_arb: RTL and testbench

- Bus-master sequencer that owns the `qar_spi` register port. It shares the SPI between two requesters using round-robin arbitration.
- Each accepted request is a 1–4 byte full-duplex transaction. The block programs CS_SELECT and CTRL, then pushes each byte, polls STATUS, and pops RX.
- It returns the assembled RX word with a done/error pulse.
- It sits between the MCU-side requesters (CPU mailbox, flash boot loader) and the SPI register port, replacing direct CPU access.

---
 rtl/qar_spi_seq_arb.sv | 234 +++++++++++++++++++++++
 tb/tb_qar_spi_seq_arb.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qar_spi_seq_arb.sv
// qar_spi_seq_arb
//   Round-robin bus-master sequencer that owns the qar_spi register port on
//   behalf of two requesters. It runs one 1-4 byte full-duplex transfer per
//   grant: it programs CS_SELECT and CTRL, then for each byte it polls STATUS
//   for tx_ready, writes TXDATA, polls for rx_ready and pops RXDATA. When the
//   transfer ends it returns the assembled RX word with a done/err pulse.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   req[1:0]         per-requester request, held until that requester's done
//   req_cs[7:0]      requester i chip-select one-hot in [4i+3:4i]
//   req_len[5:0]     requester i byte count in [3i+2:3i] (valid 1..4)
//   req_txd[63:0]    requester i TX bytes in [32i+31:32i], byte0 sent first
//   grant[1:0]       one-hot, acceptance through done cycle
//   done[1:0]        one-cycle completion pulse to the granted requester
//   err[1:0]         coincident with done when the transfer failed
//   rx_data[31:0]    received bytes, byte k in [8k+7:8k]
//   bus_write        SPI register write strobe
//   bus_read         SPI register read strobe
//   addr_word[5:0]   SPI register word address
//   wdata[31:0]      SPI write data
//   bus_rdata[31:0]  SPI read data, combinational with bus_read
//   spi_irq          reserved, unused
module qar_spi_seq_arb #(
   parameter int unsigned TIMEOUT = 4096,
   parameter logic [2:0]  MODE    = 3'b000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req,
   input  logic [7:0]  req_cs,
   input  logic [5:0]  req_len,
   input  logic [63:0] req_txd,
   output logic [1:0]  grant,
   output logic [1:0]  done,
   output logic [1:0]  err,
   output logic [31:0] rx_data,
   output logic        bus_write,
   output logic        bus_read,
   output logic [5:0]  addr_word,
   output logic [31:0] wdata,
   input  logic [31:0] bus_rdata,
   input  logic        spi_irq
);

   localparam logic [5:0]  A_CTRL   = 6'd0;
   localparam logic [5:0]  A_STATUS = 6'd1;
   localparam logic [5:0]  A_TXDATA = 6'd3;
   localparam logic [5:0]  A_RXDATA = 6'd4;
   localparam logic [5:0]  A_CS     = 6'd5;
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_CHECK,
      S_WR_CS,
      S_WR_CTRL,
      S_POLL_TX,
      S_WR_TX,
      S_POLL_RX,
      S_RD_RX,
      S_FIN
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  grant_q, grant_d;
   logic        last_q,  last_d;
   logic [3:0]  cs_q,    cs_d;
   logic [2:0]  len_q,   len_d;
   logic [31:0] txd_q,   txd_d;
   logic [31:0] rx_q,    rx_d;
   logic [1:0]  idx_q,   idx_d;
   logic [15:0] wait_q,  wait_d;
   logic        fail_q,  fail_d;
   logic        win;

   // Only STATUS bits and the RX byte are consumed.
   logic unused_inputs;
   assign unused_inputs = ^{spi_irq, bus_rdata[31:8]};

   assign grant   = grant_q;
   assign rx_data = rx_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         last_q  <= 1'b1;
         cs_q    <= '0;
         len_q   <= '0;
         txd_q   <= '0;
         rx_q    <= '0;
         idx_q   <= '0;
         wait_q  <= '0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cs_q    <= cs_d;
         len_q   <= len_d;
         txd_q   <= txd_d;
         rx_q    <= rx_d;
         idx_q   <= idx_d;
         wait_q  <= wait_d;
         fail_q  <= fail_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      last_d    = last_q;
      cs_d      = cs_q;
      len_d     = len_q;
      txd_d     = txd_q;
      rx_d      = rx_q;
      idx_d     = idx_q;
      wait_d    = wait_q;
      fail_d    = fail_q;
      win       = 1'b0;
      bus_write = 1'b0;
      bus_read  = 1'b0;
      addr_word = '0;
      wdata     = '0;
      done      = '0;
      err       = '0;

      case (state_q)
         S_IDLE: begin
            if (|req) begin
               // On a tie the requester not granted last time wins.
               win     = (req == 2'b11) ? ~last_q : req[1];
               grant_d = win ? 2'b10 : 2'b01;
               last_d  = win;
               cs_d    = win ? req_cs[7:4]    : req_cs[3:0];
               len_d   = win ? req_len[5:3]   : req_len[2:0];
               txd_d   = win ? req_txd[63:32] : req_txd[31:0];
               rx_d    = '0;
               idx_d   = '0;
               fail_d  = 1'b0;
               state_d = S_CHECK;
            end
         end

         S_CHECK: begin
            if (len_q == 3'd0 || len_q > 3'd4 || cs_q == 4'd0) begin
               fail_d  = 1'b1;
               state_d = S_FIN;
            end else begin
               state_d = S_WR_CS;
            end
         end

         S_WR_CS: begin
            bus_write = 1'b1;
            addr_word = A_CS;
            wdata     = {28'b0, cs_q};
            state_d   = S_WR_CTRL;
         end

         S_WR_CTRL: begin
            bus_write = 1'b1;
            addr_word = A_CTRL;
            wdata     = {20'b0, 1'b0, len_q, 3'b0, 1'b0, MODE, 1'b1};
            wait_d    = '0;
            state_d   = S_POLL_TX;
         end

         S_POLL_TX: begin
            bus_read  = 1'b1;
            addr_word = A_STATUS;
            if (bus_rdata[2]) begin
               fail_d  = 1'b1;
               state_d = S_FIN;
            end else if (bus_rdata[0]) begin
               state_d = S_WR_TX;
            end else if (wait_q == WAIT_LAST) begin
               fail_d  = 1'b1;
               state_d = S_FIN;
            end else begin
               wait_d = wait_q + 16'd1;
            end
         end

         S_WR_TX: begin
            bus_write = 1'b1;
            addr_word = A_TXDATA;
            wdata     = {24'b0, txd_q[{idx_q, 3'b000} +: 8]};
            wait_d    = '0;
            state_d   = S_POLL_RX;
         end

         S_POLL_RX: begin
            bus_read  = 1'b1;
            addr_word = A_STATUS;
            if (bus_rdata[2]) begin
               fail_d  = 1'b1;
               state_d = S_FIN;
            end else if (bus_rdata[1]) begin
               state_d = S_RD_RX;
            end else if (wait_q == WAIT_LAST) begin
               fail_d  = 1'b1;
               state_d = S_FIN;
            end else begin
               wait_d = wait_q + 16'd1;
            end
         end

         S_RD_RX: begin
            bus_read  = 1'b1;
            addr_word = A_RXDATA;
            rx_d[{idx_q, 3'b000} +: 8] = bus_rdata[7:0];
            if ({1'b0, idx_q} == len_q - 3'd1) begin
               state_d = S_FIN;
            end else begin
               idx_d   = idx_q + 2'd1;
               wait_d  = '0;
               state_d = S_POLL_TX;
            end
         end

         S_FIN: begin
            done    = grant_q;
            err     = fail_q ? grant_q : 2'b00;
            grant_d = '0;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_qar_spi_seq_arb.sv
module tb_qar_spi_seq_arb;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req;
   logic [7:0]  req_cs;
   logic [5:0]  req_len;
   logic [63:0] req_txd;
   logic [1:0]  grant;
   logic [1:0]  done;
   logic [1:0]  err;
   logic [31:0] rx_data;
   logic        bus_write;
   logic        bus_read;
   logic [5:0]  addr_word;
   logic [31:0] wdata;
   logic [31:0] bus_rdata;
   logic        spi_irq;

   qar_spi_seq_arb #(.TIMEOUT(16), .MODE(3'b000)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_cs    (req_cs),
      .req_len   (req_len),
      .req_txd   (req_txd),
      .grant     (grant),
      .done      (done),
      .err       (err),
      .rx_data   (rx_data),
      .bus_write (bus_write),
      .bus_read  (bus_read),
      .addr_word (addr_word),
      .wdata     (wdata),
      .bus_rdata (bus_rdata),
      .spi_irq   (spi_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- SPI register-port model ----------------
   logic       tx_hold, rx_hold, fault_armed;
   logic [7:0] rx_key;
   logic [7:0] rxq[$];
   logic       rx_avail_q, fault_q, gate_q;
   logic [7:0] rx_head_q;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxq.delete();
         rx_avail_q <= 1'b0;
         rx_head_q  <= 8'h00;
         fault_q    <= 1'b0;
         gate_q     <= 1'b0;
      end else begin
         gate_q  <= ~gate_q;
         fault_q <= fault_armed & (fault_q | (bus_write && addr_word == 6'd3));
         if (bus_write && addr_word == 6'd5) rxq.delete();
         if (bus_read && addr_word == 6'd4 && rxq.size() > 0) void'(rxq.pop_front());
         if (bus_write && addr_word == 6'd3) rxq.push_back(wdata[7:0] ^ rx_key);
         rx_avail_q <= (rxq.size() != 0);
         rx_head_q  <= (rxq.size() != 0) ? rxq[0] : 8'h00;
      end
   end

   always_comb begin
      bus_rdata = '0;
      if (bus_read) begin
         case (addr_word)
            6'd1:    bus_rdata = {28'b0, 1'b0, fault_q, rx_avail_q & gate_q & ~rx_hold, ~tx_hold};
            6'd4:    bus_rdata = {24'b0, rx_head_q};
            default: bus_rdata = '0;
         endcase
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      int          r;
      bit          e;
      logic [31:0] rx;
      int          nrd4;
      int          nacc;
      bit          chk_lat;
      bit          chk_to;
   } res_t;

   logic [37:0] exp_wr[$];
   res_t        exp_res[$];
   int          tb_last = 1;

   int         cyc = 0;
   int         n_rd4, n_acc, post_fault, g_cyc, first_poll;
   bit         fault_seen;
   logic [1:0] grant_prev;
   bit         done_prev;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst_n) begin
         grant_prev = 2'b00;
         done_prev  = 1'b0;
      end else begin
         chk("strobe_excl", {63'b0, bus_write & bus_read}, 64'd0);
         chk("grant_1hot", {63'b0, $onehot0(grant)}, 64'd1);
         if (done_prev) chk("no_regrant_after_fin", {62'b0, grant}, 64'd0);
         if (grant != 2'b00 && grant_prev == 2'b00) begin
            n_rd4 = 0; n_acc = 0; post_fault = 0; g_cyc = cyc;
            first_poll = -1; fault_seen = 0;
         end
         if (bus_write || bus_read) begin
            n_acc++;
            if (fault_seen) post_fault++;
         end
         if (bus_read && addr_word == 6'd1 && first_poll < 0) first_poll = cyc;
         if (bus_read && addr_word == 6'd1 && bus_rdata[2]) fault_seen = 1;
         if (bus_read && addr_word == 6'd4) n_rd4++;
         if (bus_write) begin
            if (exp_wr.size() == 0) chk("wr_unexpected", {26'b0, addr_word, wdata}, '1);
            else chk("wr", {26'b0, addr_word, wdata}, {26'b0, exp_wr.pop_front()});
         end
         if (done != 2'b00) begin
            if (exp_res.size() == 0) begin
               chk("done_unexpected", {62'b0, done}, 64'd0);
            end else begin
               res_t t;
               logic [1:0] m;
               t = exp_res.pop_front();
               m = (t.r == 1) ? 2'b10 : 2'b01;
               chk("done", {62'b0, done}, {62'b0, m});
               chk("err", {62'b0, err}, {62'b0, t.e ? m : 2'b00});
               chk("grant_at_done", {62'b0, grant}, {62'b0, m});
               chk("rx_data", {32'b0, rx_data}, {32'b0, t.rx});
               chk("rx_reads", 64'(n_rd4), 64'(t.nrd4));
               chk("acc_after_fault", 64'(post_fault), 64'd0);
               if (t.nacc >= 0) chk("bus_accesses", 64'(n_acc), 64'(t.nacc));
               if (t.chk_lat) chk("lat_le3", {63'b0, (cyc - g_cyc) <= 3}, 64'd1);
               if (t.chk_to) chk("timeout_lat", 64'(cyc - first_poll), 64'd16);
            end
         end else begin
            chk("err_without_done", {62'b0, err}, 64'd0);
         end
         grant_prev = grant;
         done_prev  = (done != 2'b00);
      end
   end

   // ---------------- stimulus helpers ----------------
   // kind: 0 normal, 1 invalid, 2 fault in POLL_RX, 3 tx_ready timeout
   task automatic push_txn(input int r, input logic [3:0] cs, input logic [2:0] len,
                           input logic [31:0] txd, input int kind);
      res_t t;
      logic [7:0] b;
      t.r = r; t.e = (kind != 0); t.rx = '0; t.nrd4 = 0; t.nacc = -1;
      t.chk_lat = 0; t.chk_to = 0;
      if (kind == 1) begin
         t.nacc = 0; t.chk_lat = 1;
      end else begin
         exp_wr.push_back({6'd5, 28'b0, cs});
         exp_wr.push_back({6'd0, 32'h1 | (32'(len) << 8)});
         if (kind == 0) begin
            for (int k = 0; k < int'(len); k++) begin
               b = 8'(txd >> (8 * k));
               exp_wr.push_back({6'd3, 24'b0, b});
               t.rx = t.rx | (32'(b ^ rx_key) << (8 * k));
            end
            t.nrd4 = int'(len);
         end else if (kind == 2) begin
            exp_wr.push_back({6'd3, 24'b0, txd[7:0]});
         end else begin
            t.chk_to = 1;
         end
      end
      exp_res.push_back(t);
      tb_last = r;
   endtask

   task automatic set_req(input int r, input logic [3:0] cs, input logic [2:0] len,
                          input logic [31:0] txd);
      if (r == 1) begin
         req_cs[7:4] = cs; req_len[5:3] = len; req_txd[63:32] = txd;
      end else begin
         req_cs[3:0] = cs; req_len[2:0] = len; req_txd[31:0] = txd;
      end
   endtask

   task automatic wait_done(input logic [1:0] mask);
      logic [1:0] pend;
      pend = mask;
      for (int i = 0; i < 400 && pend != 2'b00; i++) begin
         @(negedge clk);
         if (done[0]) begin req[0] = 1'b0; pend[0] = 1'b0; end
         if (done[1]) begin req[1] = 1'b0; pend[1] = 1'b0; end
      end
      chk("wait_done", {62'b0, pend}, 64'd0);
      @(negedge clk);
   endtask

   task automatic single(input int r, input logic [3:0] cs, input logic [2:0] len,
                         input logic [31:0] txd, input int kind);
      set_req(r, cs, len, txd);
      push_txn(r, cs, len, txd, kind);
      req[r] = 1'b1;
      wait_done((r == 1) ? 2'b10 : 2'b01);
   endtask

   task automatic tie(input logic [3:0] cs0, input logic [2:0] len0, input logic [31:0] txd0,
                      input logic [3:0] cs1, input logic [2:0] len1, input logic [31:0] txd1);
      set_req(0, cs0, len0, txd0);
      set_req(1, cs1, len1, txd1);
      if (tb_last == 1) begin
         push_txn(0, cs0, len0, txd0, 0);
         push_txn(1, cs1, len1, txd1, 0);
      end else begin
         push_txn(1, cs1, len1, txd1, 0);
         push_txn(0, cs0, len0, txd0, 0);
      end
      req = 2'b11;
      wait_done(2'b11);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      bit found;
      rst_n = 1'b0; req = '0; req_cs = '0; req_len = '0; req_txd = '0; spi_irq = 1'b0;
      tx_hold = 1'b0; rx_hold = 1'b0; fault_armed = 1'b0; rx_key = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_grant", {62'b0, grant}, 64'd0);
      chk("rst_done_err", {60'b0, done, err}, 64'd0);
      chk("rst_strobes", {62'b0, bus_write, bus_read}, 64'd0);
      chk("rst_addr_wdata", {26'b0, addr_word, wdata}, 64'd0);
      chk("rst_rx_data", {32'b0, rx_data}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // single transfer on each requester, loopback then XOR-ed MISO
      single(0, 4'b0001, 3'd1, 32'h0000_00A5, 0);
      rx_key = 8'h5A;
      single(1, 4'b1000, 3'd2, 32'h0000_C33C, 0);

      // simultaneous requests, twice in a row
      tie(4'b0001, 3'd2, 32'h0000_1234, 4'b0010, 3'd1, 32'h0000_00F0);
      tie(4'b0100, 3'd3, 32'h00AB_CDEF, 4'b0001, 3'd2, 32'h0000_7788);

      // four-byte transfer, MISO returns the same byte sequence
      rx_key = 8'h00;
      single(0, 4'b0010, 3'd4, 32'h4433_2211, 0);
      rx_key = 8'hFF;
      single(1, 4'b0001, 3'd3, 32'h0055_AA01, 0);

      // invalid requests never touch the bus
      single(1, 4'b0001, 3'd0, 32'h0000_0011, 1);
      single(0, 4'b0001, 3'd5, 32'h0000_0022, 1);
      single(1, 4'b0000, 3'd2, 32'h0000_0033, 1);

      // fault seen in POLL_RX
      fault_armed = 1'b1;
      single(0, 4'b0100, 3'd2, 32'h0000_9966, 2);
      fault_armed = 1'b0;
      @(negedge clk);

      // tx_ready never rises
      tx_hold = 1'b1;
      single(1, 4'b0010, 3'd1, 32'h0000_0077, 3);
      tx_hold = 1'b0;

      // asynchronous reset while waiting in POLL_RX of a 3-byte transfer
      rx_key = 8'h00;
      rx_hold = 1'b1;
      set_req(0, 4'b0100, 3'd3, 32'h00CC_BBAA);
      push_txn(0, 4'b0100, 3'd3, 32'h00CC_BBAA, 0);
      req[0] = 1'b1;
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (bus_write && addr_word == 6'd3) found = 1;
      end
      chk("reach_poll_rx", {63'b0, found}, 64'd1);
      repeat (2) @(negedge clk);
      chk("pre_rst_grant", {62'b0, grant}, 64'd1);
      chk("pre_rst_polling", {63'b0, bus_read}, 64'd1);
      #2 rst_n = 1'b0;
      req = 2'b00;
      #1;
      chk("async_rst_grant", {62'b0, grant}, 64'd0);
      chk("async_rst_done", {60'b0, done, err}, 64'd0);
      chk("async_rst_strobes", {62'b0, bus_write, bus_read}, 64'd0);
      chk("async_rst_rx", {32'b0, rx_data}, 64'd0);
      exp_wr.delete();
      exp_res.delete();
      tb_last = 1;
      rx_hold = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // after reset a tie goes to requester 0 first
      tie(4'b1000, 3'd1, 32'h0000_0042, 4'b0100, 3'd2, 32'h0000_1357);

      chk("exp_wr_drained", 64'(exp_wr.size()), 64'd0);
      chk("exp_res_drained", 64'(exp_res.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
